// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// master drives the request side; slave is the transmitter itself.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic             abort;
  logic             use_default;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, use_default, pattern, reps,
    input  out_bit, out_valid, busy, done
  );

  modport slave (
    input  start, abort, use_default, pattern, reps,
    output out_bit, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends reps+1 copies of a PAT_W-bit pattern, MSB first.
// Define SEQ_PATTERN_TX_GAP_EN to insert one idle GAP cycle between repetitions.
module seq_pattern_tx #(
  parameter int               PAT_W       = 4,
  parameter int               REP_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b0101
) (
  input logic             clk,
  input logic             reset,
  seq_pattern_tx_if.slave bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
`ifdef SEQ_PATTERN_TX_GAP_EN
    , GAP = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shadow_q, shadow_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [REP_W-1:0] rep_idx_q, rep_idx_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] sel_idx;

  // Outputs are computed one cycle ahead so every port comes straight from a flop;
  // bit_idx always names the bit currently on out_bit.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    reps_d      = reps_q;
    bit_idx_d   = bit_idx_q;
    rep_idx_d   = rep_idx_q;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    sel_idx     = '0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          shadow_d    = bus.use_default ? PAT_DEFAULT : bus.pattern;
          reps_d      = bus.reps;
          bit_idx_d   = '0;
          rep_idx_d   = '0;
          state_d     = SHIFT;
          out_bit_d   = shadow_d[PAT_W-1];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bit_idx_q == LAST_IDX) begin
          if (rep_idx_q == reps_q) begin
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            rep_idx_d = rep_idx_q + REP_W'(1);
            bit_idx_d = '0;
            busy_d    = 1'b1;
`ifdef SEQ_PATTERN_TX_GAP_EN
            state_d   = GAP;
`else
            state_d     = SHIFT;
            out_bit_d   = shadow_q[PAT_W-1];
            out_valid_d = 1'b1;
`endif
          end
        end else begin
          bit_idx_d   = bit_idx_q + IDX_W'(1);
          sel_idx     = LAST_IDX - bit_idx_d;
          out_bit_d   = shadow_q[sel_idx];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

`ifdef SEQ_PATTERN_TX_GAP_EN
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          state_d     = SHIFT;
          out_bit_d   = shadow_q[PAT_W-1];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
`endif

      // Abort is deliberately not looked at here so a finishing transfer still reports done.
      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      reps_q      <= '0;
      bit_idx_q   <= '0;
      rep_idx_q   <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      reps_q      <= reps_d;
      bit_idx_q   <= bit_idx_d;
      rep_idx_q   <= rep_idx_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx; cycle c means c clocks after start was sampled.
// Expected streams follow SEQ_PATTERN_TX_GAP_EN when the bench is built with that macro.
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int REP_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W)) bus ();

  seq_pattern_tx #(
    .PAT_W      (PAT_W),
    .REP_W      (REP_W),
    .PAT_DEFAULT(4'b0101)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b0; bus.use_default = 1'b0;
    bus.pattern = 4'hF; bus.reps = 4'h0;
    tick; tick;
    compared += 4;
    if (bus.out_bit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_bit: got %b expected 0", bus.out_bit); end
    if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    bus.start = 1'b0;
    reset = 1'b1;
    tick;
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_release_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_default;
    logic [3:0] exp_bits;
    logic ev, eb, ed, ebusy;
    exp_bits = 4'b0101;
    bus.use_default = 1'b1; bus.pattern = 4'b1010; bus.reps = 4'h0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0; bus.pattern = 4'b0000; bus.use_default = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      ev = (c <= 4); eb = ev ? exp_bits[4-c] : 1'b0; ed = (c == 5); ebusy = (c <= 5);
      compared += 4;
      if (bus.out_valid !== ev) begin mismatched++; $display("[TB] FAIL default_valid c%0d: got %b expected %b", c, bus.out_valid, ev); end
      if (bus.out_bit !== eb) begin mismatched++; $display("[TB] FAIL default_bit c%0d: got %b expected %b", c, bus.out_bit, eb); end
      if (bus.done !== ed) begin mismatched++; $display("[TB] FAIL default_done c%0d: got %b expected %b", c, bus.done, ed); end
      if (bus.busy !== ebusy) begin mismatched++; $display("[TB] FAIL default_busy c%0d: got %b expected %b", c, bus.busy, ebusy); end
      tick;
    end
  endtask

  task automatic test_repeat;
    logic [15:0] vmask, bits;
    int len, ndone, nbusy;
    logic ev, eb;
`ifdef SEQ_PATTERN_TX_GAP_EN
    len = 14; vmask = 16'b0011110111101111; bits = 16'b0011000110001100;
`else
    len = 12; vmask = 16'b0000111111111111; bits = 16'b0000110011001100;
`endif
    ndone = 0; nbusy = 0;
    bus.pattern = 4'b1100; bus.reps = 4'd2; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= len + 2; c++) begin
      ev = (c <= len) ? vmask[len-c] : 1'b0;
      eb = (c <= len) ? bits[len-c] : 1'b0;
      compared += 2;
      if (bus.out_valid !== ev) begin mismatched++; $display("[TB] FAIL repeat_valid c%0d: got %b expected %b", c, bus.out_valid, ev); end
      if (bus.out_bit !== eb) begin mismatched++; $display("[TB] FAIL repeat_bit c%0d: got %b expected %b", c, bus.out_bit, eb); end
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) nbusy++;
      tick;
    end
    compared += 2;
    if (ndone != 1) begin mismatched++; $display("[TB] FAIL repeat_done_count: got %0d expected 1", ndone); end
    if (nbusy != len + 1) begin mismatched++; $display("[TB] FAIL repeat_busy_cycles: got %0d expected %0d", nbusy, len + 1); end
  endtask

  task automatic test_max_reps;
    logic [3:0] pat;
    int nvalid, ndone, nbusy, exp_busy;
    pat = 4'b1010;
`ifdef SEQ_PATTERN_TX_GAP_EN
    exp_busy = 80;
`else
    exp_busy = 65;
`endif
    nvalid = 0; ndone = 0; nbusy = 0;
    bus.pattern = pat; bus.reps = 4'hF; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (bus.out_valid === 1'b1) begin
        compared++;
        if (bus.out_bit !== pat[3 - (nvalid % 4)]) begin
          mismatched++;
          $display("[TB] FAIL maxreps_bit n%0d: got %b expected %b", nvalid, bus.out_bit, pat[3 - (nvalid % 4)]);
        end
        nvalid++;
      end else begin
        compared++;
        if (bus.out_bit !== 1'b0) begin mismatched++; $display("[TB] FAIL maxreps_idle_bit c%0d: got %b expected 0", c, bus.out_bit); end
      end
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) nbusy++;
      tick;
    end
    compared += 3;
    if (nvalid != 64) begin mismatched++; $display("[TB] FAIL maxreps_bit_count: got %0d expected 64", nvalid); end
    if (ndone != 1) begin mismatched++; $display("[TB] FAIL maxreps_done_count: got %0d expected 1", ndone); end
    if (nbusy != exp_busy) begin mismatched++; $display("[TB] FAIL maxreps_busy_cycles: got %0d expected %0d", nbusy, exp_busy); end
  endtask

  task automatic test_abort;
    logic [3:0] exp_bits;
    int ndone;
    exp_bits = 4'b1011;
    bus.pattern = exp_bits; bus.reps = 4'd1; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      compared += 2;
      if (bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_pre_valid c%0d: got %b expected 1", c, bus.out_valid); end
      if (bus.out_bit !== exp_bits[4-c]) begin mismatched++; $display("[TB] FAIL abort_pre_bit c%0d: got %b expected %b", c, bus.out_bit, exp_bits[4-c]); end
      if (c == 3) bus.abort = 1'b1;
      tick;
    end
    bus.abort = 1'b0;
    compared += 4;
    if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_bit !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_bit: got %b expected 0", bus.out_bit); end
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done: got %b expected 0", bus.done); end
    for (int c = 0; c < 3; c++) begin
      tick;
      compared++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL abort_after c%0d: got done=%b busy=%b expected 0 0", c, bus.done, bus.busy);
      end
    end
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    compared += 2;
    if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_restart_c1: got valid=%b bit=%b expected 1 1", bus.out_valid, bus.out_bit); end
    tick;
    if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_restart_c2: got valid=%b bit=%b expected 1 0", bus.out_valid, bus.out_bit); end
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      tick;
      if (bus.done === 1'b1) ndone++;
    end
    compared++;
    if (ndone != 1) begin mismatched++; $display("[TB] FAIL abort_restart_done: got %0d expected 1", ndone); end
  endtask

  task automatic test_busy_ignore;
    logic [3:0] exp_bits;
    logic ev, eb, ed, ebusy;
    exp_bits = 4'b1001;
    bus.pattern = exp_bits; bus.reps = 4'd0; bus.use_default = 1'b0; bus.start = 1'b1;
    tick;
    for (int c = 1; c <= 7; c++) begin
      ev = (c <= 4); eb = ev ? exp_bits[4-c] : 1'b0; ed = (c == 5); ebusy = (c <= 5);
      compared += 4;
      if (bus.out_valid !== ev) begin mismatched++; $display("[TB] FAIL busy_ign_valid c%0d: got %b expected %b", c, bus.out_valid, ev); end
      if (bus.out_bit !== eb) begin mismatched++; $display("[TB] FAIL busy_ign_bit c%0d: got %b expected %b", c, bus.out_bit, eb); end
      if (bus.done !== ed) begin mismatched++; $display("[TB] FAIL busy_ign_done c%0d: got %b expected %b", c, bus.done, ed); end
      if (bus.busy !== ebusy) begin mismatched++; $display("[TB] FAIL busy_ign_busy c%0d: got %b expected %b", c, bus.busy, ebusy); end
      if (c <= 4) begin
        bus.pattern = ~bus.pattern; bus.reps = 4'hF; bus.use_default = 1'b1;
      end
      if (c >= 5) bus.start = 1'b0;
      tick;
    end
    bus.use_default = 1'b0; bus.reps = 4'd0;
  endtask

  task automatic test_reset_mid;
    bus.pattern = 4'b1111; bus.reps = 4'd3; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
    compared += 4;
    if (bus.out_bit !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_bit: got %b expected 0", bus.out_bit); end
    if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_valid: got %b expected 0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done: got %b expected 0", bus.done); end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      compared++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL midrst_release c%0d: got busy=%b valid=%b done=%b expected 0 0 0", c, bus.busy, bus.out_valid, bus.done);
      end
    end
    // Start and abort together in IDLE: abort wins and nothing is queued.
    bus.start = 1'b1; bus.abort = 1'b1;
    tick;
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      compared++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL start_abort_idle c%0d: got busy=%b valid=%b expected 0 0", c, bus.busy, bus.out_valid);
      end
      tick;
    end
  endtask

  task automatic test_loopback;
    logic [3:0] det;
    int run, nvalid, total, aligned, exp_total;
`ifdef SEQ_PATTERN_TX_GAP_EN
    exp_total = 4;
`else
    exp_total = 7;
`endif
    det = '0; run = 0; nvalid = 0; total = 0; aligned = 0;
    bus.pattern = 4'b0101; bus.reps = 4'd3; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (bus.out_valid === 1'b1) begin
        det = {det[2:0], bus.out_bit};
        run++; nvalid++;
        if (run >= 4 && det == 4'b0101) begin
          total++;
          if (nvalid % 4 == 0) aligned++;
        end
      end else begin
        det = '0; run = 0;
      end
      tick;
    end
    compared += 2;
    if (aligned != 4) begin mismatched++; $display("[TB] FAIL loopback_copies: got %0d expected 4", aligned); end
    if (total != exp_total) begin mismatched++; $display("[TB] FAIL loopback_matches: got %0d expected %0d", total, exp_total); end
  endtask

  initial begin
    test_reset;
    test_default;
    test_repeat;
    test_max_reps;
    test_abort;
    test_busy_ignore;
    test_reset_mid;
    test_loopback;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
